writeback_ctrl: RTL

WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

---
 rtl/writeback_ctrl_pkg.sv | 7 +
 rtl/writeback_ctrl_fifo.sv | 65 ++++++
 rtl/writeback_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/writeback_ctrl_pkg.sv
// writeback_ctrl_pkg: shared widths, default queue depth and sequencer state type
package writeback_ctrl_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int DEPTH_DEF = 4;
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} wb_state_e;
endpackage

// File: rtl/writeback_ctrl_fifo.sv
// wb_fifo: circular write queue exposing every slot for bypass lookup
module wb_fifo
   import writeback_ctrl_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 push,
   input  logic [REG_ADDR_W-1:0]                push_rd,
   input  logic [DATA_W-1:0]                    push_data,
   input  logic                                 pop,
   output logic [REG_ADDR_W-1:0]                head_rd,
   output logic [DATA_W-1:0]                    head_data,
   output logic [PW-1:0]                        head_ptr,
   output logic [3:0]                           count,
   output logic [DEPTH-1:0]                     ent_valid,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]     ent_rd,
   output logic [DEPTH-1:0][DATA_W-1:0]         ent_data
);
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [3:0] count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
   logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
   always_comb begin
      head_d = pop ? head_q + 1'b1 : head_q;
      tail_d = push ? tail_q + 1'b1 : tail_q;
      count_d = count_q + 4'(push) - 4'(pop);
      valid_d = valid_q;
      rd_d = rd_q;
      data_d = data_q;
      if (pop) valid_d[head_q] = 1'b0;
      if (push) begin
         valid_d[tail_q] = 1'b1;
         rd_d[tail_q] = push_rd;
         data_d[tail_q] = push_data;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
         valid_q <= '0;
         rd_q <= '0;
         data_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
         rd_q <= rd_d;
         data_q <= data_d;
      end
   end
   assign head_rd = rd_q[head_q];
   assign head_data = data_q[head_q];
   assign head_ptr = head_q;
   assign count = count_q;
   assign ent_valid = valid_q;
   assign ent_rd = rd_q;
   assign ent_data = data_q;
endmodule

// File: rtl/writeback_ctrl.sv
// writeback_ctrl: queues writebacks and paces them into the register file with a bypass lookup
module writeback_ctrl
   import writeback_ctrl_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_valid,
   output logic                  wb_ready,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0]     wb_data,
   output logic [REG_ADDR_W-1:0] WriteRegister,
   output logic [DATA_W-1:0]     WriteData,
   output logic                  RegWrite,
   input  logic [REG_ADDR_W-1:0] lookup_rs,
   output logic                  lookup_hit,
   output logic [DATA_W-1:0]     lookup_data,
   output logic                  busy,
   output logic [3:0]            count
);
   localparam int PW = $clog2(DEPTH);
   wb_state_e state_q, state_d;
   logic regwrite_q, regwrite_d;
   logic [REG_ADDR_W-1:0] wr_rd_q, wr_rd_d, head_rd;
   logic [DATA_W-1:0] wr_data_q, wr_data_d, head_data;
   logic [PW-1:0] head_ptr;
   logic [DEPTH-1:0] ent_valid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
   logic [DEPTH-1:0][DATA_W-1:0] ent_data;
   logic push, pop;
   assign wb_ready = count < 4'(DEPTH);
   assign push = wb_valid && wb_ready && wb_rd != '0;
   assign pop = (state_q == IDLE || state_q == HOLD) && count != '0;
   assign busy = count != '0 || state_q != IDLE;
   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push),
      .push_rd(wb_rd),
      .push_data(wb_data),
      .pop(pop),
      .head_rd(head_rd),
      .head_data(head_data),
      .head_ptr(head_ptr),
      .count(count),
      .ent_valid(ent_valid),
      .ent_rd(ent_rd),
      .ent_data(ent_data)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         regwrite_q <= 1'b0;
         wr_rd_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q <= state_d;
         regwrite_q <= regwrite_d;
         wr_rd_q <= wr_rd_d;
         wr_data_q <= wr_data_d;
      end
   end
   always_comb begin
      state_d = state_q == SETUP ? STROBE : state_q == STROBE ? HOLD : pop ? SETUP : IDLE;
   end
   always_comb begin
      regwrite_d = state_d == STROBE;
      wr_rd_d = pop ? head_rd : wr_rd_q;
      wr_data_d = pop ? head_data : wr_data_q;
   end
   assign RegWrite = regwrite_q;
   assign WriteRegister = wr_rd_q;
   assign WriteData = wr_data_q;
   // walk oldest to newest so the youngest match overrides; the in-flight entry is older than any queued one
   always_comb begin
      lookup_hit = 1'b0;
      lookup_data = '0;
      if (lookup_rs != '0) begin
         if ((state_q == SETUP || state_q == STROBE) && wr_rd_q == lookup_rs) begin
            lookup_hit = 1'b1;
            lookup_data = wr_data_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[head_ptr + PW'(i)] && ent_rd[head_ptr + PW'(i)] == lookup_rs) begin
               lookup_hit = 1'b1;
               lookup_data = ent_data[head_ptr + PW'(i)];
            end
         end
      end
   end
endmodule
